// File: rtl/vram_pkg.sv
// Shared encodings for the VRAM arbiter: host command opcodes, read-return
// tags and the default bus widths.
package vram_pkg;

  localparam int VRAM_ADDR_W = 16;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Which requester a read issued to the VRAM belongs to.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_HOST  = 2'd2
  } tag_e;

  typedef enum logic [1:0] {
    ISSUE_IDLE  = 2'd0,
    ISSUE_FETCH = 2'd1,
    ISSUE_HOST  = 2'd2
  } issue_e;

  function automatic tag_e issue_tag(input issue_e issue, input op_e op);
    tag_e tag;
    tag = TAG_NONE;
    if (issue == ISSUE_FETCH) begin
      tag = TAG_FETCH;
    end else if (issue == ISSUE_HOST && op == OP_RD) begin
      tag = TAG_HOST;
    end
    return tag;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the display-fetch, host-command and VRAM-macro signals of the arbiter.
// master: display/host/memory side; slave: the arbiter itself.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
);

  logic              pix_tick;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;

  logic              host_wr;
  logic              host_rd;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_full;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              host_ovf;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output pix_tick, fetch_req, fetch_addr,
    input  fetch_data, fetch_valid,
    output host_wr, host_rd, host_addr, host_wdata,
    input  host_full, host_rdata, host_rvalid, host_ovf,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );

  modport slave (
    input  pix_tick, fetch_req, fetch_addr,
    output fetch_data, fetch_valid,
    input  host_wr, host_rd, host_addr, host_wdata,
    output host_full, host_rdata, host_rvalid, host_ovf,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

endinterface

// File: rtl/vram_cmd_fifo.sv
// Host command FIFO for the VRAM arbiter; a push while full is only taken
// when a pop frees an entry in the same cycle.
module vram_cmd_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                   pllclk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = store[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge pllclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pllclk) begin
    if (do_push) begin
      store[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch owns the cycle after each pix_tick,
// queued host commands fill the rest. Optional stall counter: VRAM_ARB_STATS_EN.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        pllclk,
  input  logic        rst_n,
  vram_arbiter_if.slave bus
`ifdef VRAM_ARB_STATS_EN
  ,
  input  logic        stall_clr,
  output logic [15:0] stall_cnt
`endif
);

  localparam int CMD_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              fetch_slot;
  logic              push_req;
  issue_e            issue;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CMD_W-1:0]  cmd_in;
  logic [CMD_W-1:0]  head;
  op_e               cmd_op;
  op_e               head_op;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic              mem_re_q;
  tag_e              tag_issue_q;
  tag_e              tag_data_q;

  logic [DATA_W-1:0] fetch_data_q;
  logic              fetch_valid_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              host_rvalid_q;
  logic              host_ovf_q;

  assign fetch_slot = bus.pix_tick && bus.fetch_req;
  assign push_req   = bus.host_wr || bus.host_rd;
  assign cmd_op     = bus.host_wr ? OP_WR : OP_RD;
  assign cmd_in     = {cmd_op, bus.host_addr, bus.host_wdata};
  assign head_op    = op_e'(head[CMD_W-1]);
  assign head_addr  = head[CMD_W-2 -: ADDR_W];
  assign head_data  = head[DATA_W-1:0];

  vram_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .pllclk (pllclk),
    .rst_n  (rst_n),
    .push   (push_req),
    .pop    (fifo_pop),
    .din    (cmd_in),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // The decision taken this cycle is what the registered memory port shows
  // next cycle, so a tick always claims the cycle right after it.
  always_comb begin
    issue = ISSUE_IDLE;
    if (fetch_slot) begin
      issue = ISSUE_FETCH;
    end else if (!fifo_empty) begin
      issue = ISSUE_HOST;
    end
  end

  assign fifo_pop = (issue == ISSUE_HOST);

  always_ff @(posedge pllclk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      tag_issue_q <= TAG_NONE;
    end else begin
      tag_issue_q <= issue_tag(issue, head_op);
      case (issue)
        ISSUE_FETCH: begin
          mem_addr_q <= bus.fetch_addr;
          mem_we_q   <= 1'b0;
          mem_re_q   <= 1'b1;
        end
        ISSUE_HOST: begin
          mem_addr_q  <= head_addr;
          mem_wdata_q <= head_data;
          mem_we_q    <= (head_op == OP_WR);
          mem_re_q    <= (head_op == OP_RD);
        end
        default: begin
          mem_we_q <= 1'b0;
          mem_re_q <= 1'b0;
        end
      endcase
    end
  end

  // Tags ride alongside the VRAM read latency so each return goes to its owner.
  always_ff @(posedge pllclk or negedge rst_n) begin
    if (!rst_n) begin
      tag_data_q    <= TAG_NONE;
      fetch_data_q  <= '0;
      fetch_valid_q <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      tag_data_q    <= tag_issue_q;
      fetch_valid_q <= (tag_data_q == TAG_FETCH);
      host_rvalid_q <= (tag_data_q == TAG_HOST);
      if (tag_data_q == TAG_FETCH) begin
        fetch_data_q <= bus.mem_rdata;
      end
      if (tag_data_q == TAG_HOST) begin
        host_rdata_q <= bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge pllclk or negedge rst_n) begin
    if (!rst_n) begin
      host_ovf_q <= 1'b0;
    end else if (push_req && fifo_full && !fifo_pop) begin
      host_ovf_q <= 1'b1;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge pllclk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (fetch_slot && !fifo_empty && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_re      = mem_re_q;
  assign bus.fetch_data  = fetch_data_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_ovf    = host_ovf_q;
  assign bus.host_full   = (fifo_count == CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed scenarios plus randomized
// fetch/host traffic against a behavioural VRAM and ordering model.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  typedef struct {
    int        due;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic pllclk = 1'b0;
  logic rst_n  = 1'b0;
  always #2 pllclk = ~pllclk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef VRAM_ARB_STATS_EN
  logic        stall_clr = 1'b0;
  logic [15:0] stall_cnt;
`endif

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .pllclk (pllclk),
    .rst_n  (rst_n),
    .bus    (bus)
`ifdef VRAM_ARB_STATS_EN
    ,
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt)
`endif
  );

  logic [7:0] vram   [65536];
  logic [7:0] refMem [65536];

  exp_t       fetchQ[$];
  exp_t       slotQ[$];
  logic [7:0] hostQ[$];
  int         issueQ[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int weCount = 0;
  int hostReCount = 0;
  int lastWeCycle = -1;
  int lastHostReCycle = -1;

  always @(posedge pllclk) cyc++;

  // Behavioural VRAM macro: one-cycle read latency, write on mem_we.
  always @(posedge pllclk) begin
    if (bus.mem_we) vram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= vram[bus.mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One cycle of stimulus; the expected responses are queued as it is issued.
  task automatic applyStimulus(input bit tick, input bit freq, input logic [15:0] faddr,
                               input bit wr, input bit rd, input logic [15:0] haddr,
                               input logic [7:0] hwd, input bit accept, input bit gateFull);
    @(posedge pllclk);
    #1;
    if (gateFull && bus.host_full) begin
      wr = 1'b0;
      rd = 1'b0;
    end
    bus.pix_tick   = tick;
    bus.fetch_req  = freq;
    bus.fetch_addr = faddr;
    bus.host_wr    = wr;
    bus.host_rd    = rd;
    bus.host_addr  = haddr;
    bus.host_wdata = hwd;
    if (tick && freq) begin
      slotQ.push_back('{cyc + 1, faddr, 8'h00});
      fetchQ.push_back('{cyc + 3, faddr, refMem[faddr]});
    end
    if ((wr || rd) && accept) begin
      if (wr) refMem[haddr] = hwd;
      else    hostQ.push_back(refMem[haddr]);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 8'h0, 0, 0);
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 200 && (hostQ.size() != 0 || fetchQ.size() != 0); k++) idle(1);
    checkOutput("drain_host", hostQ.size(), 0);
    checkOutput("drain_fetch", fetchQ.size(), 0);
  endtask

  // Monitor: compares every presented DUT output against the queued expectations.
  exp_t monE;
  int   monIssue;
  bit   isSlot;
  always @(negedge pllclk) begin
    if (!rst_n) begin
      checkOutput("reset_outputs", 32'(|{bus.fetch_valid, bus.host_rvalid, bus.host_full, bus.host_ovf,
                                        bus.mem_we, bus.mem_re, bus.fetch_data, bus.host_rdata,
                                        bus.mem_addr, bus.mem_wdata}), 0);
    end else begin
      isSlot = 1'b0;
      checkOutput("mem_we_re_excl", 32'(bus.mem_we & bus.mem_re), 0);
      if (slotQ.size() != 0 && slotQ[0].due == cyc) begin
        monE = slotQ.pop_front();
        isSlot = 1'b1;
        checkOutput("slot_mem_re", 32'(bus.mem_re), 1);
        checkOutput("slot_mem_we", 32'(bus.mem_we), 0);
        checkOutput("slot_mem_addr", 32'(bus.mem_addr), 32'(monE.addr));
      end
      if (!isSlot && bus.mem_re) begin
        issueQ.push_back(cyc);
        hostReCount++;
        lastHostReCycle = cyc;
      end
      if (!isSlot && bus.mem_we) begin
        weCount++;
        lastWeCycle = cyc;
      end
      if (bus.fetch_valid) begin
        if (fetchQ.size() == 0) begin
          checkOutput("fetch_unexpected", 1, 0);
        end else begin
          monE = fetchQ.pop_front();
          checkOutput("fetch_cycle", cyc, monE.due);
          checkOutput("fetch_data", 32'(bus.fetch_data), 32'(monE.data));
        end
      end else if (fetchQ.size() != 0 && fetchQ[0].due <= cyc) begin
        monE = fetchQ.pop_front();
        checkOutput("fetch_missing", 0, 1);
      end
      if (bus.host_rvalid) begin
        if (hostQ.size() == 0) begin
          checkOutput("host_rvalid_unexpected", 1, 0);
        end else begin
          checkOutput("host_rdata", 32'(bus.host_rdata), 32'(hostQ.pop_front()));
        end
        if (issueQ.size() == 0) begin
          checkOutput("host_issue_missing", 1, 0);
        end else begin
          monIssue = issueQ.pop_front();
          checkOutput("host_read_latency", cyc - monIssue, 2);
        end
      end
    end
  end

  initial begin
    int c0;
    int wStart;
    int r0;
    int w0;
    for (int i = 0; i < 65536; i++) begin
      vram[i]   = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
      refMem[i] = vram[i];
    end
    vram[16'h0123]   = 8'hA5;
    refMem[16'h0123] = 8'hA5;
    bus.pix_tick = 0; bus.fetch_req = 0; bus.fetch_addr = 0;
    bus.host_wr = 0; bus.host_rd = 0; bus.host_addr = 0; bus.host_wdata = 0;

    repeat (3) @(posedge pllclk);
    #1 rst_n = 1'b1;

    // Single fetch from a known word.
    applyStimulus(1, 1, 16'h0123, 0, 0, 16'h0, 8'h0, 1, 0);
    idle(5);

    // Write then read the same address.
    applyStimulus(0, 0, 16'h0, 1, 0, 16'h0010, 8'h3C, 1, 0);
    c0 = cyc;
    applyStimulus(0, 0, 16'h0, 0, 1, 16'h0010, 8'h00, 1, 0);
    idle(6);
    checkOutput("wr_issue_cycle", lastWeCycle, c0 + 2);
    checkOutput("rd_issue_cycle", lastHostReCycle, c0 + 3);

    // Host write queued alongside a fetch tick must avoid the reserved cycle.
    applyStimulus(1, 1, 16'h0200, 1, 0, 16'h8100, 8'h77, 1, 0);
    c0 = cyc;
    idle(6);
    checkOutput("wr_after_slot", lastWeCycle, c0 + 2);

    // Randomized traffic: fetches in the low half, host commands in the high half.
    for (int i = 0; i < 600; i++) begin
      bit wrSel;
      bit doHost;
      wrSel  = ($urandom_range(0, 1) == 1);
      doHost = ($urandom_range(0, 2) != 0);
      applyStimulus((i % 6 == 0) || ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) != 0),
                    16'($urandom_range(0, 16'h7FFF)),
                    doHost && wrSel, doHost && !wrSel,
                    16'h8000 | 16'($urandom_range(0, 15)),
                    8'($urandom), 1, 1);
    end
    waitDrain();
    checkOutput("ovf_clear", 32'(bus.host_ovf), 0);

`ifdef VRAM_ARB_STATS_EN
    idle(1);
    stall_clr = 1'b1;
    idle(1);
    stall_clr = 1'b0;
    applyStimulus(0, 0, 16'h0, 1, 0, 16'h8200, 8'h11, 1, 0);
    for (int k = 0; k < 10; k++) applyStimulus(1, 1, 16'h0300 + 16'(k), 0, 0, 16'h0, 8'h0, 1, 0);
    idle(1);
    checkOutput("stall_cnt_10", 32'(stall_cnt), 10);
    stall_clr = 1'b1;
    idle(1);
    stall_clr = 1'b0;
    checkOutput("stall_cnt_clr", 32'(stall_cnt), 0);
    waitDrain();
`endif

    // Overflow: every cycle reserved, five pushes, the fifth is dropped.
    wStart = weCount;
    applyStimulus(1, 1, 16'h0400, 0, 0, 16'h0, 8'h0, 1, 0);
    for (int k = 0; k < 5; k++)
      applyStimulus(1, 1, 16'h0401 + 16'(k), 1, 0, 16'h9000 + 16'(k), 8'hC0 + 8'(k), (k < 4), 0);
    checkOutput("ovf_full", 32'(bus.host_full), 1);
    applyStimulus(1, 1, 16'h0410, 0, 0, 16'h0, 8'h0, 1, 0);
    checkOutput("ovf_sticky", 32'(bus.host_ovf), 1);
    for (int k = 0; k < 3; k++) applyStimulus(1, 1, 16'h0411 + 16'(k), 0, 0, 16'h0, 8'h0, 1, 0);
    checkOutput("ovf_blocked", weCount - wStart, 0);
    idle(10);
    checkOutput("ovf_drained", weCount - wStart, 4);
    checkOutput("ovf_not_full", 32'(bus.host_full), 0);
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 16'h0, 0, 1, 16'h9000 + 16'(k), 8'h0, 1, 0);
    waitDrain();

    // Reset while a host read is in flight.
    applyStimulus(0, 0, 16'h0, 0, 1, 16'h8003, 8'h0, 1, 0);
    idle(3);
    rst_n = 1'b0;
    hostQ.delete();
    issueQ.delete();
    fetchQ.delete();
    slotQ.delete();
    repeat (3) @(posedge pllclk);
    #1 rst_n = 1'b1;
    r0 = hostReCount;
    w0 = weCount;
    idle(10);
    checkOutput("post_reset_no_reads", hostReCount - r0, 0);
    checkOutput("post_reset_no_writes", weCount - w0, 0);
    checkOutput("post_reset_ovf", 32'(bus.host_ovf), 0);
    checkOutput("post_reset_full", 32'(bus.host_full), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
